// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and the CBD sampler state encoding.
package kyber_pkg;

  localparam int          KYBER_Q      = 3329;
  localparam int          KYBER_N      = 256;
  localparam int          COEFF_W      = 12;
  localparam logic [13:0] PRF_LEN_ETA2 = 14'd1024;

  typedef logic [COEFF_W-1:0] coeff_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ1     = 3'd1,
    ST_REQ2     = 3'd2,
    ST_WAIT_PRF = 3'd3,
    ST_EMIT     = 3'd4,
    ST_DONE     = 3'd5
  } cbd_state_e;

endpackage

// File: rtl/cbd2_coeff.sv
// Centred binomial (eta=2) decode of one 4-bit nibble into a mod-q coefficient.
module cbd2_coeff
  import kyber_pkg::*;
(
  input  logic [3:0] nibble,
  output coeff_t     coeff
);

  localparam coeff_t Q_C = coeff_t'(KYBER_Q);

  logic [1:0] a_s;
  logic [1:0] b_s;

  // Sum bit pairs, then fold the signed difference into [0, q-1]
  always_comb begin
    a_s = {1'b0, nibble[0]} + {1'b0, nibble[1]};
    b_s = {1'b0, nibble[2]} + {1'b0, nibble[3]};
    if (a_s >= b_s) begin
      coeff = {10'd0, a_s - b_s};
    end else begin
      coeff = Q_C - {10'd0, b_s - a_s};
    end
  end

endmodule

// File: rtl/cbd2_sampler.sv
// Drives a SHAKE256 PRF request, buffers its 1024-bit squeeze and streams
// 256 CBD(eta=2) coefficients over valid/ready.
module cbd2_sampler
  import kyber_pkg::*;
#(
  parameter int ETA     = 2,
  parameter int N       = 256,
  parameter int Q       = 3329,
  parameter int COEFF_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [255:0]       seed,
  input  logic [7:0]         nonce,
  output logic               busy,
  output logic               prf_enable,
  output logic [255:0]       prf_seed,
  output logic [7:0]         prf_nonce,
  output logic [13:0]        prf_output_len,
  input  logic               prf_done,
  input  logic [1023:0]      prf_data,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic [COEFF_W-1:0] coeff_out,
  output logic [7:0]         coeff_idx,
  output logic               done
);

  if (ETA != 2 || Q != KYBER_Q || COEFF_W != 12) begin : g_param_check
    $error("cbd2_sampler: only ETA=2, Q=3329, COEFF_W=12 are supported");
  end

  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  cbd_state_e          state_r;
  cbd_state_e          state_next_s;
  logic                busy_r;
  logic                prf_enable_r;
  logic                done_r;
  logic [255:0]        seed_r;
  logic [7:0]          nonce_r;
  logic [1023:0]       buf_r;
  logic [7:0]          idx_r;
  logic [COEFF_W-1:0]  coeff_r;
  logic                valid_r;
  logic [7:0]          sel_idx_s;
  logic [3:0]          nibble_s;
  coeff_t              coeff_s;

  // Next-state logic; prf_done only counts once the peer has been restarted
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_REQ1;
        else       state_next_s = ST_IDLE;
      end
      ST_REQ1: state_next_s = ST_REQ2;
      ST_REQ2: state_next_s = ST_WAIT_PRF;
      ST_WAIT_PRF: begin
        if (prf_done) state_next_s = ST_EMIT;
        else          state_next_s = ST_WAIT_PRF;
      end
      ST_EMIT: begin
        if (valid_r && coeff_ready && (idx_r == LAST_IDX)) state_next_s = ST_DONE;
        else                                               state_next_s = ST_EMIT;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Nibble selection: the coefficient being loaded is the current one until
  // valid is up, afterwards the one following the accepted index
  always_comb begin
    if (valid_r) sel_idx_s = idx_r + 8'd1;
    else         sel_idx_s = idx_r;
    nibble_s = buf_r[{sel_idx_s, 2'b00} +: 4];
  end

  cbd2_coeff u_coeff (
    .nibble (nibble_s),
    .coeff  (coeff_s)
  );

  // State register and state-derived registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      prf_enable_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      prf_enable_r <= (state_next_s == ST_REQ1) || (state_next_s == ST_REQ2);
      done_r       <= (state_next_s == ST_DONE);
    end
  end

  // Request capture, PRF buffer and coefficient stream registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r  <= 256'd0;
      nonce_r <= 8'd0;
      buf_r   <= 1024'd0;
      idx_r   <= 8'd0;
      coeff_r <= {COEFF_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            seed_r  <= seed;
            nonce_r <= nonce;
            idx_r   <= 8'd0;
          end
        end
        ST_WAIT_PRF: begin
          if (prf_done) buf_r <= prf_data;
        end
        ST_EMIT: begin
          if (!valid_r) begin
            coeff_r <= coeff_s;
            valid_r <= 1'b1;
          end else if (coeff_ready) begin
            if (idx_r == LAST_IDX) begin
              valid_r <= 1'b0;
            end else begin
              idx_r   <= idx_r + 8'd1;
              coeff_r <= coeff_s;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign prf_enable     = prf_enable_r;
  assign prf_seed       = seed_r;
  assign prf_nonce      = nonce_r;
  assign prf_output_len = PRF_LEN_ETA2;
  assign coeff_valid    = valid_r;
  assign coeff_out      = coeff_r;
  assign coeff_idx      = idx_r;
  assign done           = done_r;

endmodule

// File: tb/tb_cbd2_sampler.sv
// Directed bench for cbd2_sampler with a behavioural SHAKE256 peer that parks
// done high until the next enable and returns nonce-dependent squeeze data.
module tb_cbd2_sampler;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [255:0]  seed = 256'd0;
  logic [7:0]    nonce = 8'd0;
  logic          busy, prf_enable, coeff_valid, done;
  logic [255:0]  prf_seed;
  logic [7:0]    prf_nonce;
  logic [13:0]   prf_output_len;
  logic          prf_done = 1'b0;
  logic [1023:0] prf_data = 1024'd0;
  logic          coeff_ready = 1'b0;
  logic [11:0]   coeff_out;
  logic [7:0]    coeff_idx;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [11:0] got_coeff [256];
  logic [7:0]  got_idx [256];
  int got_n, done_n, stall_err, en_cycles, seed_err;
  bit timeout;

  cbd2_sampler dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .nonce(nonce),
    .busy(busy), .prf_enable(prf_enable), .prf_seed(prf_seed), .prf_nonce(prf_nonce),
    .prf_output_len(prf_output_len), .prf_done(prf_done), .prf_data(prf_data),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_out(coeff_out),
    .coeff_idx(coeff_idx), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [1023:0] gen_data(input logic [7:0] n);
    logic [1023:0] d;
    logic [3:0] nib;
    case (n)
      8'd0:    nib = 4'h0;
      8'd1:    nib = 4'hF;
      8'd2:    nib = 4'h1;
      8'd3:    nib = 4'h4;
      default: nib = 4'h8;
    endcase
    for (int j = 0; j < 256; j++) d[4*j +: 4] = nib;
    if (n == 8'd1) d[15:0] = 16'h41C3;
    return d;
  endfunction

  // Expected coefficient j for nonce 1: nibbles 3, C, 1, 4 then F
  function automatic logic [11:0] exp_pattern(input int j);
    case (j)
      0:       return 12'd2;
      1:       return 12'd3327;
      2:       return 12'd1;
      3:       return 12'd3328;
      default: return 12'd0;
    endcase
  endfunction

  int stub_cnt = 0;
  always @(posedge clk) begin
    if (prf_enable) begin
      prf_done <= 1'b0;
      stub_cnt <= 5;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        prf_done <= 1'b1;
        prf_data <= gen_data(prf_nonce);
      end
    end
  end

  task automatic do_run(input logic [7:0] n, input logic [255:0] sd, input bit rand_ready, input bit poke);
    logic [11:0] so;
    logic [7:0]  si;
    logic stalled, r;
    int post;
    got_n = 0; done_n = 0; stall_err = 0; en_cycles = 0; seed_err = 0; timeout = 0;
    stalled = 1'b0; post = -1; so = 12'd0; si = 8'd0;
    @(negedge clk);
    seed = sd; nonce = n; start = 1'b1; coeff_ready = 1'b0;
    @(negedge clk);
    if (poke) begin
      seed = ~sd;
      nonce = n ^ 8'hFF;
    end else begin
      start = 1'b0;
    end
    for (int c = 0; c < 2000 && post != 0; c++) begin
      if (prf_enable) en_cycles++;
      if (busy && (prf_seed !== sd || prf_nonce !== n)) seed_err++;
      if (stalled && (!coeff_valid || coeff_out !== so || coeff_idx !== si)) stall_err++;
      if (done) begin
        done_n++;
        if (post < 0) post = 4;
      end
      if (poke) start = busy;
      r = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      coeff_ready = r;
      if (coeff_valid && r) begin
        if (got_n < 256) begin
          got_coeff[got_n] = coeff_out;
          got_idx[got_n] = coeff_idx;
        end
        got_n++;
      end
      stalled = coeff_valid && !r;
      so = coeff_out; si = coeff_idx;
      if (post > 0) post--;
      @(negedge clk);
    end
    if (post != 0) timeout = 1;
    start = 1'b0;
    coeff_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_cnt++;
    if ({busy, prf_enable, coeff_valid, done} !== 4'b0000) $display("FAIL reset_flags got=%b want=0000", {busy, prf_enable, coeff_valid, done});
    else pass_cnt++;
    check_cnt++;
    if (coeff_out !== 12'd0 || coeff_idx !== 8'd0) $display("FAIL reset_coeff got=%0d/%0d want=0/0", coeff_out, coeff_idx);
    else pass_cnt++;
    check_cnt++;
    if (prf_seed !== 256'd0 || prf_nonce !== 8'd0) $display("FAIL reset_prf_regs got nonce=%0d want=0", prf_nonce);
    else pass_cnt++;
    check_cnt++;
    if (prf_output_len !== 14'd1024) $display("FAIL output_len got=%0d want=1024", prf_output_len);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_zero_stream;
    do_run(8'd0, {8{32'h1234_5678}}, 1'b0, 1'b0);
    check_cnt++;
    if (timeout || got_n !== 256) $display("FAIL zero_count got=%0d timeout=%0d want=256", got_n, timeout);
    else pass_cnt++;
    check_cnt++;
    if (done_n !== 1) $display("FAIL zero_done_pulses got=%0d want=1", done_n);
    else pass_cnt++;
    check_cnt++;
    if (en_cycles !== 2) $display("FAIL zero_enable_cycles got=%0d want=2", en_cycles);
    else pass_cnt++;
    for (int j = 0; j < 256 && j < got_n; j++) begin
      check_cnt++;
      if (got_coeff[j] !== 12'd0 || got_idx[j] !== 8'(j)) $display("FAIL zero_coeff[%0d] got=%0d idx=%0d want=0 idx=%0d", j, got_coeff[j], got_idx[j], j);
      else pass_cnt++;
    end
  endtask

  task automatic test_pattern(input bit rand_ready);
    do_run(8'd1, {8{32'hCAFE_F00D}}, rand_ready, 1'b0);
    check_cnt++;
    if (timeout || got_n !== 256) $display("FAIL pattern_count rr=%0d got=%0d want=256", rand_ready, got_n);
    else pass_cnt++;
    check_cnt++;
    if (stall_err !== 0) $display("FAIL pattern_stall_stable rr=%0d got=%0d want=0", rand_ready, stall_err);
    else pass_cnt++;
    for (int j = 0; j < 256 && j < got_n; j++) begin
      check_cnt++;
      if (got_coeff[j] !== exp_pattern(j) || got_idx[j] !== 8'(j))
        $display("FAIL pattern_coeff[%0d] rr=%0d got=%0d idx=%0d want=%0d idx=%0d", j, rand_ready, got_coeff[j], got_idx[j], exp_pattern(j), j);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      do_run(8'(2 + k), {8{32'h0BAD_BEEF}}, 1'b0, 1'b0);
      check_cnt++;
      if (en_cycles !== 2) $display("FAIL b2b_enable_cycles run=%0d got=%0d want=2", k, en_cycles);
      else pass_cnt++;
      check_cnt++;
      if (timeout || got_n !== 256 || done_n !== 1) $display("FAIL b2b_count run=%0d got=%0d done=%0d want=256/1", k, got_n, done_n);
      else pass_cnt++;
      for (int j = 0; j < 256 && j < got_n; j++) begin
        check_cnt++;
        if (got_coeff[j] !== (k == 0 ? 12'd1 : 12'd3328))
          $display("FAIL b2b_coeff[%0d] run=%0d got=%0d want=%0d", j, k, got_coeff[j], (k == 0 ? 1 : 3328));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_emit;
    bit found;
    found = 0;
    @(negedge clk);
    seed = 256'd7; nonce = 8'd2; start = 1'b1; coeff_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (coeff_valid && coeff_idx == 8'd100) found = 1;
      else @(negedge clk);
    end
    check_cnt++;
    if (!found) $display("FAIL midreset_reach_idx100 got=0 want=1");
    else pass_cnt++;
    rst = 1'b1;
    coeff_ready = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({busy, prf_enable, coeff_valid, done} !== 4'b0000 || coeff_out !== 12'd0 || coeff_idx !== 8'd0)
      $display("FAIL midreset_outputs got flags=%b coeff=%0d idx=%0d want=0", {busy, prf_enable, coeff_valid, done}, coeff_out, coeff_idx);
    else pass_cnt++;
    check_cnt++;
    if (prf_seed !== 256'd0 || prf_nonce !== 8'd0) $display("FAIL midreset_prf_regs got nonce=%0d want=0", prf_nonce);
    else pass_cnt++;
    rst = 1'b0;
    do_run(8'd0, 256'd9, 1'b0, 1'b0);
    check_cnt++;
    if (timeout || got_n !== 256 || done_n !== 1) $display("FAIL midreset_rerun got=%0d done=%0d want=256/1", got_n, done_n);
    else pass_cnt++;
    for (int j = 0; j < 256 && j < got_n; j++) begin
      check_cnt++;
      if (got_idx[j] !== 8'(j) || got_coeff[j] !== 12'd0) $display("FAIL midreset_idx[%0d] got=%0d want=%0d", j, got_idx[j], j);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored;
    do_run(8'd1, {8{32'h5A5A_A5A5}}, 1'b0, 1'b1);
    check_cnt++;
    if (seed_err !== 0) $display("FAIL ignore_seed_nonce_changed got=%0d want=0", seed_err);
    else pass_cnt++;
    check_cnt++;
    if (en_cycles !== 2 || done_n !== 1) $display("FAIL ignore_restart got en=%0d done=%0d want=2/1", en_cycles, done_n);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL ignore_busy_after got=%0d want=0", busy);
    else pass_cnt++;
    check_cnt++;
    if (timeout || got_n !== 256) $display("FAIL ignore_count got=%0d want=256", got_n);
    else pass_cnt++;
    for (int j = 0; j < 256 && j < got_n; j++) begin
      check_cnt++;
      if (got_coeff[j] !== exp_pattern(j)) $display("FAIL ignore_coeff[%0d] got=%0d want=%0d", j, got_coeff[j], exp_pattern(j));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_pattern(1'b0);
    test_pattern(1'b1);
    test_back_to_back();
    test_reset_mid_emit();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
